// File: rtl/led_pattern_counter.sv
// LED pattern counter: steps an internal count or bounce position on each rising
// edge of divided_clk and decodes it to the LED bus in one of four display modes.
module led_pattern_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divided_clk,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] led_count,
    output logic             step_pulse,
    output logic             wrap_pulse
);

    localparam int unsigned POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_GRAY   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    logic             prev_clk_q, prev_clk_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    mode_e            mode_q, mode_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    logic             rise;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [POS_W-1:0] pos_inc;
    logic [POS_W-1:0] pos_dec;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_clk_q <= 1'b0;
            cnt_q      <= '0;
            pos_q      <= '0;
            dir_q      <= 1'b0;
            mode_q     <= MODE_UP;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            prev_clk_q <= prev_clk_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
        end
    end

    assign rise    = divided_clk & ~prev_clk_q;
    assign sum     = {1'b0, cnt_q} + {1'b0, STEP_W};
    assign diff    = cnt_q - STEP_W;
    assign borrow  = (cnt_q < STEP_W);
    assign pos_inc = pos_q + POS_W'(1);
    assign pos_dec = pos_q - POS_W'(1);

    // Next state: load beats an accepted step; binary modes and bounce keep separate state.
    always_comb begin
        prev_clk_d = divided_clk;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        mode_d     = mode_e'(mode);
        step_d     = 1'b0;
        wrap_d     = 1'b0;

        if (load) begin
            cnt_d = load_value;
            pos_d = '0;
            dir_d = 1'b0;
        end else if (rise && enable) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_UP, MODE_GRAY: begin
                    cnt_d  = sum[WIDTH-1:0];
                    wrap_d = sum[WIDTH];
                end
                MODE_DOWN: begin
                    cnt_d  = diff;
                    wrap_d = borrow;
                end
                MODE_BOUNCE: begin
                    if (!dir_q) begin
                        pos_d = pos_inc;
                        if (pos_inc == POS_LAST) begin
                            dir_d  = 1'b1;
                            wrap_d = 1'b1;
                        end
                    end else begin
                        pos_d = pos_dec;
                        if (pos_dec == '0) begin
                            dir_d  = 1'b0;
                            wrap_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // LED decode uses registered state only.
    always_comb begin
        led_count = '0;
        case (mode_q)
            MODE_UP, MODE_DOWN: led_count = cnt_q;
            MODE_GRAY:          led_count = cnt_q ^ (cnt_q >> 1);
            MODE_BOUNCE:        led_count = WIDTH'(1) << pos_q;
            default:            led_count = '0;
        endcase
    end

    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Directed bench for led_pattern_counter: an 8-bit STEP=1 instance and a 4-bit
// STEP=3 instance share all inputs and are checked phase by phase.
module tb_led_pattern_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       divided_clk;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_value;
    logic [3:0] load_value4;

    logic [7:0] led8;
    logic       step8, wrap8;
    logic [3:0] led4;
    logic       step4, wrap4;

    int checks = 0;
    int errors = 0;

    assign load_value4 = load_value[3:0];

    always #5 clk = ~clk;

    led_pattern_counter #(.WIDTH(8), .STEP(1)) dut8 (
        .clk(clk), .reset(reset), .divided_clk(divided_clk), .enable(enable),
        .mode(mode), .load(load), .load_value(load_value),
        .led_count(led8), .step_pulse(step8), .wrap_pulse(wrap8)
    );

    led_pattern_counter #(.WIDTH(4), .STEP(3)) dut4 (
        .clk(clk), .reset(reset), .divided_clk(divided_clk), .enable(enable),
        .mode(mode), .load(load), .load_value(load_value4),
        .led_count(led4), .step_pulse(step4), .wrap_pulse(wrap4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] bounce_led [8];
        logic       bounce_wrap [8];
        bounce_led  = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2, 4'd4};
        bounce_wrap = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset
        reset = 1'b0; divided_clk = 1'b0; enable = 1'b0; mode = 2'b00;
        load = 1'b0; load_value = 8'h00;
        tick(); tick();
        check("reset_led8", 32'(led8), 32'h0);
        check("reset_step8", 32'(step8), 32'h0);
        check("reset_wrap8", 32'(wrap8), 32'h0);
        reset = 1'b1; enable = 1'b1;

        // Up count through wrap: 300 edges
        for (int i = 1; i <= 300; i++) begin
            divided_clk = 1'b1; tick();
            check("up_led", 32'(led8), 32'(i % 256));
            check("up_step", 32'(step8), 32'h1);
            check("up_wrap", 32'(wrap8), (i == 256) ? 32'h1 : 32'h0);
            divided_clk = 1'b0; tick();
            check("up_step_low", 32'(step8), 32'h0);
        end
        check("up_final", 32'(led8), 32'd44);

        // Load coincident with an edge discards the edge
        load = 1'b1; load_value = 8'h3C; divided_clk = 1'b1; tick();
        check("load_led", 32'(led8), 32'h3C);
        check("load_step", 32'(step8), 32'h0);
        check("load_wrap", 32'(wrap8), 32'h0);
        load = 1'b0; divided_clk = 1'b0; tick();
        divided_clk = 1'b1; tick();
        check("load_next_led", 32'(led8), 32'h3D);
        check("load_next_step", 32'(step8), 32'h1);
        divided_clk = 1'b0; tick();

        // Down from 0 borrows
        load = 1'b1; load_value = 8'h00; tick();
        load = 1'b0; mode = 2'b01; tick();
        divided_clk = 1'b1; tick();
        check("down_led", 32'(led8), 32'hFF);
        check("down_wrap", 32'(wrap8), 32'h1);
        divided_clk = 1'b0; tick();
        divided_clk = 1'b1; tick();
        check("down2_led", 32'(led8), 32'hFE);
        check("down2_wrap", 32'(wrap8), 32'h0);
        divided_clk = 1'b0; tick();

        // Gray: load 5 shows 7, step to 6 shows 5
        mode = 2'b10; load = 1'b1; load_value = 8'h05; tick();
        load = 1'b0; tick();
        check("gray_load_led", 32'(led8), 32'h07);
        divided_clk = 1'b1; tick();
        check("gray_led", 32'(led8), 32'h05);
        check("gray_step", 32'(step8), 32'h1);
        divided_clk = 1'b0; tick();

        // STEP=3 WIDTH=4: 14 -> 1 with wrap
        mode = 2'b00; load = 1'b1; load_value = 8'h0E; tick();
        load = 1'b0; tick();
        check("s3_load_led4", 32'(led4), 32'hE);
        divided_clk = 1'b1; tick();
        check("s3_led4", 32'(led4), 32'h1);
        check("s3_wrap4", 32'(wrap4), 32'h1);
        check("s3_step4", 32'(step4), 32'h1);
        check("s1_led8", 32'(led8), 32'h0F);
        check("s1_wrap8", 32'(wrap8), 32'h0);
        divided_clk = 1'b0; tick();

        // Disabled edges are lost
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            divided_clk = 1'b1; tick();
            check("dis_led", 32'(led8), 32'h0F);
            check("dis_step", 32'(step8), 32'h0);
            divided_clk = 1'b0; tick();
        end
        enable = 1'b1; tick();
        check("en_noreplay_led", 32'(led8), 32'h0F);
        check("en_noreplay_step", 32'(step8), 32'h0);

        // Held-high divided_clk: one step only
        divided_clk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_led", 32'(led8), 32'h10);
            check("held_step", 32'(step8), (i == 0) ? 32'h1 : 32'h0);
        end
        divided_clk = 1'b0; tick();

        // Bounce on the 4-bit instance
        load = 1'b1; load_value = 8'h09; tick();
        load = 1'b0; mode = 2'b11; tick();
        check("bounce_start4", 32'(led4), 32'h1);
        for (int i = 0; i < 8; i++) begin
            divided_clk = 1'b1; tick();
            check("bounce_led4", 32'(led4), 32'(bounce_led[i]));
            check("bounce_wrap4", 32'(wrap4), 32'(bounce_wrap[i]));
            check("bounce_step4", 32'(step4), 32'h1);
            divided_clk = 1'b0; tick();
        end
        check("bounce_led8", 32'(led8), 32'h40);
        mode = 2'b00; tick();
        check("retain_cnt4", 32'(led4), 32'h9);
        mode = 2'b11; tick();
        check("retain_pos4", 32'(led4), 32'h4);

        // Reset mid-run with edge and load coincident
        mode = 2'b00; load = 1'b1; load_value = 8'h76; tick();
        load = 1'b0; tick();
        divided_clk = 1'b1; tick();
        check("pre_rst_led", 32'(led8), 32'h77);
        divided_clk = 1'b0; tick();
        reset = 1'b0; divided_clk = 1'b1; load = 1'b1; load_value = 8'hFF; tick();
        check("rst_led", 32'(led8), 32'h0);
        check("rst_step", 32'(step8), 32'h0);
        check("rst_wrap", 32'(wrap8), 32'h0);
        reset = 1'b1; load = 1'b0; tick();
        check("post_rst_led", 32'(led8), 32'h1);
        check("post_rst_step", 32'(step8), 32'h1);
        divided_clk = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_counter.md
Name: led_pattern_counter

Overview:
Parametrised successor to the single-mode LED counter. Detects rising edges of the divided clock (from clk_divider) and advances an internal state on each one. Drives a WIDTH-bit LED bus in one of four display modes: binary up, binary down, Gray-code up, and single-LED bounce. Adds enable, synchronous load, and step/wrap status pulses for downstream sequencing logic.

Parameters:
WIDTH, 8, LED bus and counter width; legal range 2..32.
STEP, 1, increment or decrement amount per accepted edge in binary and Gray modes; legal range 1..2^WIDTH-1.

Ports:
clk  input  1  system clock; all state updates on posedge clk
reset  input  1  synchronous reset, active-low (0 = reset)
divided_clk  input  1  slow clock from clk_divider, synchronous to clk; treated as a level
enable  input  1  1 = accept steps; 0 = hold state (edge detector keeps tracking)
mode  input  2  00 binary up, 01 binary down, 10 Gray up, 11 bounce
load  input  1  synchronous load strobe
load_value  input  WIDTH  value loaded into cnt
led_count  output  WIDTH  LED drive, decoded from state per mode_q
step_pulse  output  1  one-cycle pulse on every accepted step
wrap_pulse  output  1  one-cycle pulse on wrap or direction reversal

Behaviour:
- State registers: prev_clk (1b), cnt (WIDTH), pos (clog2(WIDTH)), dir (1b, 0 = toward MSB), mode_q (2b), step_pulse, wrap_pulse.
- Reset (reset==0 at posedge): prev_clk=0, cnt=0, pos=0, dir=0, mode_q=00, step_pulse=0, wrap_pulse=0.
- Outputs during and after reset: led_count=0 in modes 00, 01, 10; led_count=1 in mode 11.
- Edge: edge = divided_clk & ~prev_clk. prev_clk <= divided_clk every non-reset cycle, regardless of enable or load.
- A high divided_clk on the first cycle after reset release counts as an edge.
- mode_q <= mode every non-reset cycle. A mode change affects decoding and stepping one cycle later.
- Priority, highest first: reset > load > accepted step (edge & enable).
- Load: cnt=load_value, pos=0, dir=0. step_pulse=0 and wrap_pulse=0 that cycle. A coincident edge is discarded.
- Accepted step: result is registered at the same posedge that samples the edge. led_count changes the cycle after divided_clk is first seen high.
- Mode 00 step: cnt <= cnt+STEP mod 2^WIDTH. wrap_pulse=1 if the unsigned sum carries out.
- Mode 01 step: cnt <= cnt-STEP mod 2^WIDTH. wrap_pulse=1 if the subtraction borrows.
- Mode 10 step: same arithmetic and wrap rule as mode 00. led_count = cnt ^ (cnt>>1).
- Mode 11 step, dir=0: pos++. If the new pos == WIDTH-1, dir<=1 and wrap_pulse=1.
- Mode 11 step, dir=1: pos--. If the new pos == 0, dir<=0 and wrap_pulse=1.
- Mode 11 state: cnt untouched. led_count = 1<<pos, exactly one LED lit at all times.
- Modes 00, 01, 10 leave pos and dir untouched. Switching modes resumes each mode from its retained state.
- step_pulse = 1 for exactly one cycle per accepted step, otherwise 0. wrap_pulse is only ever high with step_pulse.
- enable=0: no state change, no pulses. An edge arriving while disabled is lost and is not replayed when enable rises.
- divided_clk held high: exactly one step only. divided_clk toggling every clk: one step per two clk cycles.
- Reset mid-operation: takes effect at the next posedge regardless of the other inputs. Pulses clear that cycle.
- led_count decoding is combinational from registered state (cnt, pos, mode_q) only. There is no combinational path from any input.

Test Plan:
- Reset then up count: WIDTH=8, STEP=1, mode=00, enable=1, 300 divided_clk rising edges -> led_count 0,1,…,255,0,…,44. Exactly one step_pulse per edge. wrap_pulse only on the 255->0 step.
- Down, gray and STEP: mode=01 from 0 -> first step gives led_count=255 with wrap_pulse=1. Mode=10, load_value=5, next edge -> cnt=6, led_count=0x05. STEP=3, WIDTH=4, mode=00, from 14 -> 1 with wrap_pulse=1.
- Bounce: WIDTH=4, mode=11, 8 edges from reset -> led_count 2,4,8,4,2,1,2,4. wrap_pulse on the steps producing 8 and 1.
- Load versus edge: load=1, load_value=0x3C coincident with an edge -> led_count=0x3C, no step_pulse. A step on the next edge gives 0x3D.
- Enable and held level: enable=0 across 3 edges -> no change. divided_clk held high 10 cycles with enable=1 -> exactly one step.
- Reset mid-run: count to 0x77, drive reset=0 for 1 cycle coincident with an edge and load=1 -> led_count=0, step_pulse=0, wrap_pulse=0. If divided_clk is high on the cycle after release, a step gives led_count=1.
